// File: rtl/orientation_width_fifo.sv
// Single-clock width-converting FIFO: wide words in, narrow lanes out (first-word-fall-through).
// The head word's current lane drives odata directly, so a word pushed into an empty FIFO is readable on the next cycle.
module orientation_width_fifo #(
  parameter  int OUT_W      = 16,
  parameter  int RATIO      = 8,
  parameter  int DEPTH      = 16,
  parameter  int LANE_ORDER = 0,
  localparam int IN_W       = OUT_W * RATIO,
  localparam int AW         = $clog2(DEPTH),
  localparam int LW         = $clog2(RATIO),
  localparam int UW         = $clog2(DEPTH * RATIO) + 1
) (
  input  logic             iclk,
  input  logic             ireset,
  input  logic             iflush,
  input  logic             iwrite_valid,
  input  logic [IN_W-1:0]  idata,
  output logic             owrite_ready,
  output logic             oread_valid,
  input  logic             iread_ready,
  output logic [OUT_W-1:0] odata,
  output logic [AW:0]      owrusedw,
  output logic [UW-1:0]    ordusedw
);

  logic [IN_W-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [LW-1:0]   lane;
  logic            push;
  logic            lane_xfer;
  logic            last_lane;
  logic            word_pop;
  logic [IN_W-1:0] head_word;
  logic [LW-1:0]   sel_lane;

  // No write bypass: a full FIFO refuses writes even when the head word retires this cycle.
  assign owrite_ready = ireset && !iflush && (count < (AW+1)'(DEPTH));
  assign oread_valid  = (count != '0);
  assign push         = iwrite_valid && owrite_ready;
  assign lane_xfer    = oread_valid && iread_ready;
  assign last_lane    = (lane == LW'(RATIO - 1));
  assign word_pop     = lane_xfer && last_lane;

  assign owrusedw = count;
  assign ordusedw = UW'(count) * UW'(RATIO) - UW'(lane);

  assign head_word = mem[rd_ptr];
  assign sel_lane  = (LANE_ORDER != 0) ? (LW'(RATIO - 1) - lane) : lane;

  always_comb begin
    odata = '0;
    if (oread_valid) begin
      odata = head_word[sel_lane * OUT_W +: OUT_W];
    end
  end

  always_ff @(posedge iclk) begin
    if (push) begin
      mem[wr_ptr] <= idata;
    end
  end

  // Reset and flush clear identically; reset simply wins because either one suffices.
  always_ff @(posedge iclk) begin
    if (!ireset || iflush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      lane   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (lane_xfer) begin
        if (last_lane) begin
          lane   <= '0;
          rd_ptr <= rd_ptr + AW'(1);
        end else begin
          lane <= lane + LW'(1);
        end
      end
      case ({push, word_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_orientation_width_fifo.sv
// Scoreboard bench: two default-size instances (both lane orders) share directed stimulus,
// and a small DEPTH=4/RATIO=2 instance takes random traffic to exercise pointer wrap.
module tb_orientation_width_fifo;

  localparam int OUT_W   = 16;
  localparam int RATIO   = 8;
  localparam int DEPTH   = 16;
  localparam int S_OUT_W = 8;
  localparam int S_RATIO = 2;
  localparam int S_DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, flush, wv, rr;
  logic [127:0] wdata;
  logic         wready0, rvalid0, wready1, rvalid1;
  logic [15:0]  odata0, odata1;
  logic [4:0]   wused0, wused1;
  logic [7:0]   rused0, rused1;

  logic         rst2, flush2, wv2, rr2;
  logic [15:0]  wdata2;
  logic         wready2, rvalid2;
  logic [7:0]   odata2;
  logic [2:0]   wused2;
  logic [3:0]   rused2;

  int tests  = 0;
  int failed = 0;
  int m_count [3] = '{0, 0, 0};
  int m_lane  [3] = '{0, 0, 0};
  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];
  logic [15:0] exp_q2 [$];

  orientation_width_fifo #(.OUT_W(OUT_W), .RATIO(RATIO), .DEPTH(DEPTH), .LANE_ORDER(0)) u_fifo0 (
    .iclk(clk), .ireset(rst_n), .iflush(flush), .iwrite_valid(wv), .idata(wdata),
    .owrite_ready(wready0), .oread_valid(rvalid0), .iread_ready(rr), .odata(odata0),
    .owrusedw(wused0), .ordusedw(rused0)
  );

  orientation_width_fifo #(.OUT_W(OUT_W), .RATIO(RATIO), .DEPTH(DEPTH), .LANE_ORDER(1)) u_fifo1 (
    .iclk(clk), .ireset(rst_n), .iflush(flush), .iwrite_valid(wv), .idata(wdata),
    .owrite_ready(wready1), .oread_valid(rvalid1), .iread_ready(rr), .odata(odata1),
    .owrusedw(wused1), .ordusedw(rused1)
  );

  orientation_width_fifo #(.OUT_W(S_OUT_W), .RATIO(S_RATIO), .DEPTH(S_DEPTH), .LANE_ORDER(0)) u_fifo2 (
    .iclk(clk), .ireset(rst2), .iflush(flush2), .iwrite_valid(wv2), .idata(wdata2),
    .owrite_ready(wready2), .oread_valid(rvalid2), .iread_ready(rr2), .odata(odata2),
    .owrusedw(wused2), .ordusedw(rused2)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] q_front(input int inst);
    case (inst)
      0:       return (exp_q0.size() > 0) ? exp_q0[0] : 16'hxxxx;
      1:       return (exp_q1.size() > 0) ? exp_q1[0] : 16'hxxxx;
      default: return (exp_q2.size() > 0) ? exp_q2[0] : 16'hxxxx;
    endcase
  endfunction

  task automatic q_push(input int inst, input logic [15:0] v);
    case (inst)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  task automatic q_pop(input int inst);
    case (inst)
      0:       if (exp_q0.size() > 0) void'(exp_q0.pop_front());
      1:       if (exp_q1.size() > 0) void'(exp_q1.pop_front());
      default: if (exp_q2.size() > 0) void'(exp_q2.pop_front());
    endcase
  endtask

  task automatic q_clear(input int inst);
    case (inst)
      0:       exp_q0.delete();
      1:       exp_q1.delete();
      default: exp_q2.delete();
    endcase
  endtask

  // Compares one instance against the reference model, then advances the model by the coming edge.
  task automatic check_cycle(input int inst, input int depth, input int ratio, input int order,
                             input int out_w, input logic rst_l, input logic fl, input logic w_valid,
                             input logic [127:0] w_data, input logic r_ready, input logic w_ready,
                             input logic r_valid, input logic [15:0] r_data, input logic [7:0] w_used,
                             input logic [7:0] r_used);
    logic         exp_wready;
    logic         exp_rvalid;
    logic [15:0]  exp_data;
    logic [15:0]  mask;
    logic [127:0] shifted;
    int           idx;
    string        p;
    p          = $sformatf("u%0d_", inst);
    exp_wready = rst_l && !fl && (m_count[inst] < depth);
    exp_rvalid = (m_count[inst] > 0);
    exp_data   = exp_rvalid ? q_front(inst) : 16'h0;
    check_output({p, "owrite_ready"}, 64'(w_ready), 64'(exp_wready));
    check_output({p, "oread_valid"}, 64'(r_valid), 64'(exp_rvalid));
    check_output({p, "odata"}, 64'(r_data), 64'(exp_data));
    check_output({p, "owrusedw"}, 64'(w_used), 64'(m_count[inst]));
    check_output({p, "ordusedw"}, 64'(r_used), 64'(m_count[inst] * ratio - m_lane[inst]));
    if (!rst_l || fl) begin
      m_count[inst] = 0;
      m_lane[inst]  = 0;
      q_clear(inst);
    end else begin
      if (exp_rvalid && r_ready) begin
        q_pop(inst);
        if (m_lane[inst] == ratio - 1) begin
          m_lane[inst] = 0;
          m_count[inst]--;
        end else begin
          m_lane[inst]++;
        end
      end
      if (w_valid && exp_wready) begin
        m_count[inst]++;
        mask = 16'((32'h1 << out_w) - 1);
        for (int l = 0; l < ratio; l++) begin
          idx     = (order != 0) ? (ratio - 1 - l) : l;
          shifted = w_data >> (idx * out_w);
          q_push(inst, shifted[15:0] & mask);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    check_cycle(0, DEPTH, RATIO, 0, OUT_W, rst_n, flush, wv, wdata, rr,
                wready0, rvalid0, odata0, 8'(wused0), rused0);
    check_cycle(1, DEPTH, RATIO, 1, OUT_W, rst_n, flush, wv, wdata, rr,
                wready1, rvalid1, odata1, 8'(wused1), rused1);
    check_cycle(2, S_DEPTH, S_RATIO, 0, S_OUT_W, rst2, flush2, wv2, 128'(wdata2), rr2,
                wready2, rvalid2, 16'(odata2), 8'(wused2), 8'(rused2));
  end

  function automatic logic [127:0] make_word(input int base);
    logic [127:0] w;
    for (int l = 0; l < RATIO; l++) begin
      w[l*16 +: 16] = 16'(base + l);
    end
    return w;
  endfunction

  task automatic apply_stimulus(input logic r, input logic f, input logic v,
                                input logic [127:0] d, input logic rdy);
    rst_n = r;
    flush = f;
    wv    = v;
    wdata = d;
    rr    = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; wv = 1'b0; wdata = '0; rr = 1'b0;
    rst2  = 1'b0; flush2 = 1'b0; wv2 = 1'b0; wdata2 = '0; rr2 = 1'b0;

    repeat (3) apply_stimulus(1'b0, 1'b0, 1'b1, make_word(16'h100), 1'b0);
    check_output("reset_owrite_ready", 64'(wready0), 64'd0);
    check_output("reset_oread_valid", 64'(rvalid0), 64'd0);
    check_output("reset_odata", 64'(odata0), 64'd0);
    check_output("reset_owrusedw", 64'(wused0), 64'd0);
    check_output("reset_ordusedw", 64'(rused0), 64'd0);
    rst_n = 1'b1;
    wv    = 1'b0;
    #1;
    check_output("release_owrite_ready", 64'(wready0), 64'd1);
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
    check_output("release_oread_valid", 64'(rvalid0), 64'd0);

    // Word 0x0007_0006_..._0000: lane order 0 emits 0..7, lane order 1 emits 7..0.
    apply_stimulus(1'b1, 1'b0, 1'b1, make_word(0), 1'b1);
    wv = 1'b0;
    rr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_output("order0_odata", 64'(odata0), 64'(i));
      check_output("order1_odata", 64'(odata1), 64'(7 - i));
      @(posedge clk);
      #1;
    end
    check_output("order_drained_valid", 64'(rvalid0), 64'd0);

    for (int k = 0; k < 17; k++) begin
      apply_stimulus(1'b1, 1'b0, 1'b1, make_word(16 * (k + 1)), 1'b0);
    end
    check_output("full_owrite_ready", 64'(wready0), 64'd0);
    check_output("full_owrusedw", 64'(wused0), 64'd16);
    check_output("full_ordusedw", 64'(rused0), 64'd128);
    repeat (8) apply_stimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
    check_output("after_pop_owrite_ready", 64'(wready0), 64'd1);
    check_output("after_pop_owrusedw", 64'(wused0), 64'd15);
    check_output("after_pop_ordusedw", 64'(rused0), 64'd120);

    apply_stimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
    check_output("flush_owrusedw", 64'(wused0), 64'd0);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b1, 1'b0, 1'b1, make_word(16'h200 + 16 * k), 1'b0);
    end
    repeat (7) apply_stimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
    check_output("lane7_ordusedw", 64'(rused0), 64'd17);
    apply_stimulus(1'b1, 1'b0, 1'b1, make_word(16'h400), 1'b1);
    check_output("pushpop_owrusedw", 64'(wused0), 64'd3);
    check_output("pushpop_ordusedw", 64'(rused0), 64'd24);

    apply_stimulus(1'b1, 1'b1, 1'b0, '0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b1, make_word(16'h500), 1'b0);
    repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
    check_output("midword_odata0", 64'(odata0), 64'h503);
    check_output("midword_odata1", 64'(odata1), 64'h504);
    apply_stimulus(1'b1, 1'b1, 1'b1, make_word(16'h600), 1'b1);
    check_output("flushmid_owrusedw", 64'(wused0), 64'd0);
    check_output("flushmid_ordusedw", 64'(rused0), 64'd0);
    check_output("flushmid_oread_valid", 64'(rvalid0), 64'd0);
    check_output("flushmid_odata", 64'(odata0), 64'd0);
    apply_stimulus(1'b1, 1'b0, 1'b1, make_word(16'h700), 1'b0);
    check_output("postflush_odata0", 64'(odata0), 64'h700);
    check_output("postflush_odata1", 64'(odata1), 64'h707);
    check_output("postflush_owrusedw", 64'(wused0), 64'd1);
    check_output("postflush_ordusedw", 64'(rused0), 64'd8);
    repeat (8) apply_stimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
    check_output("postflush_drained", 64'(rvalid0), 64'd0);
    apply_stimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);

    // Random traffic with rare flushes and resets; the per-cycle scoreboard does the checking.
    for (int c = 0; c < 10000; c++) begin
      rst2   = ($urandom_range(0, 499) != 0);
      flush2 = ($urandom_range(0, 199) == 0);
      wv2    = 1'($urandom_range(0, 1));
      wdata2 = 16'($urandom);
      rr2    = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    rst2   = 1'b1;
    flush2 = 1'b0;
    wv2    = 1'b0;
    rr2    = 1'b1;
    repeat (2 * S_DEPTH * S_RATIO + 2) begin
      @(posedge clk);
      #1;
    end
    check_output("random_drained", 64'(rvalid2), 64'd0);
    check_output("random_drained_ordusedw", 64'(rused2), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
